wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 87 ++++++++
 rtl/wb_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
//
// Contents:
//   REG_ADDR_W          register address width
//   DEFAULT_FIFO_DEPTH  default number of buffered port-B requests
//   AGE_MAX             saturation value of the starvation age counter
//   wb_req              writeback request {rd, data} at the default data width
package wb_arb_pkg;

    localparam int unsigned REG_ADDR_W         = 5;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 2;
    localparam int unsigned AGE_MAX            = 3;
    localparam int unsigned DEFAULT_DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]     rd;
        logic [DEFAULT_DATA_W-1:0] data;
    } wb_req;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous shift-register FIFO for port-B writeback requests.
// The head always sits in slot 0, so per-entry rd/valid are cheap to expose
// for the pending-write lookup.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push, push_rd/data    enqueue (ignored when full)
//   pop                   dequeue head (ignored when empty)
//   head_rd, head_data    oldest entry
//   count                 occupancy
//   entry_rd, entry_valid per-slot destination register and validity
module wb_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  logic [REG_ADDR_W-1:0]                push_rd,
    input  logic [W-1:0]                         push_data,
    input  logic                                 pop,
    output logic [REG_ADDR_W-1:0]                head_rd,
    output logic [W-1:0]                         head_data,
    output logic [$clog2(DEPTH+1)-1:0]           count,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entry_rd,
    output logic [DEPTH-1:0]                     entry_valid
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DEPTH-1:0][W-1:0]          data_q, data_d;
    logic [CW-1:0]                    count_q, count_d;
    logic                             push_ok, pop_ok;

    assign push_ok = push && (count_q != CW'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    always_comb begin
        rd_d    = rd_q;
        data_d  = data_q;
        count_d = count_q;
        if (pop_ok) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                rd_d[i]   = rd_q[i+1];
                data_d[i] = data_q[i+1];
            end
            count_d = count_q - 1'b1;
        end
        // Write lands just above the (post-pop) occupancy.
        if (push_ok) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (CW'(i) == count_d) begin
                    rd_d[i]   = push_rd;
                    data_d[i] = push_data;
                end
            end
            count_d = count_d + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            entry_valid[i] = CW'(i) < count_q;
        end
    end

    assign entry_rd  = rd_q;
    assign head_rd   = rd_q[0];
    assign head_data = data_q[0];
    assign count     = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Two-port register-file writeback arbiter. Port A (pipeline) has priority;
// port B (long-latency unit) requests are buffered in a FIFO and drained when
// A is idle. The granted write is registered onto the rf_* port.
//
// Optional feature: define WB_ARB_AGE_EN to enable a starvation guard that
// forces the FIFO head through after it has been blocked AGE_MAX cycles.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   a_valid/a_rd/a_data, a_ready    port A request
//   b_valid/b_rd/b_data, b_ready    port B request
//   rf_regWrite, rf_RD, rf_writeData registered register-file write
//   RS1/RS2, rs1_pending/rs2_pending pending-write lookup
//   b_count                         FIFO occupancy
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned n          = 32,
    parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              a_valid,
    input  logic [REG_ADDR_W-1:0]             a_rd,
    input  logic [n-1:0]                      a_data,
    output logic                              a_ready,
    input  logic                              b_valid,
    input  logic [REG_ADDR_W-1:0]             b_rd,
    input  logic [n-1:0]                      b_data,
    output logic                              b_ready,
    output logic                              rf_regWrite,
    output logic [REG_ADDR_W-1:0]             rf_RD,
    output logic [n-1:0]                      rf_writeData,
    input  logic [REG_ADDR_W-1:0]             RS1,
    input  logic [REG_ADDR_W-1:0]             RS2,
    output logic                              rs1_pending,
    output logic                              rs2_pending,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   b_count
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic                                  a_acc, b_acc;
    logic                                  fifo_push, fifo_pop, fifo_empty;
    logic [REG_ADDR_W-1:0]                 head_rd;
    logic [n-1:0]                          head_data;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0] entry_rd;
    logic [FIFO_DEPTH-1:0]                 entry_valid;
    logic                                  grant_we;
    logic [REG_ADDR_W-1:0]                 grant_rd;
    logic [n-1:0]                          grant_data;

    assign fifo_empty = (b_count == '0);
    assign b_ready    = (b_count < CW'(FIFO_DEPTH));
    assign a_acc      = a_valid && a_ready;
    assign b_acc      = b_valid && b_ready;
    // rd=0 writes are architecturally void, so they are accepted and dropped.
    assign fifo_push  = b_acc && (b_rd != '0);
    assign fifo_pop   = !a_acc && !fifo_empty;

`ifdef WB_ARB_AGE_EN
    logic [1:0] age_q, age_d;

    // Age only reaches AGE_MAX with a non-empty FIFO, so blocking A here
    // always hands the cycle to the head.
    assign a_ready = (age_q != 2'(AGE_MAX));

    always_comb begin
        age_d = age_q;
        if (fifo_empty || fifo_pop) begin
            age_d = '0;
        end else if (age_q != 2'(AGE_MAX)) begin
            age_d = age_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign a_ready = 1'b1;
`endif

    wb_fifo #(
        .W     (n),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .push_rd     (b_rd),
        .push_data   (b_data),
        .pop         (fifo_pop),
        .head_rd     (head_rd),
        .head_data   (head_data),
        .count       (b_count),
        .entry_rd    (entry_rd),
        .entry_valid (entry_valid)
    );

    always_comb begin
        grant_we   = 1'b0;
        grant_rd   = a_rd;
        grant_data = a_data;
        if (a_acc) begin
            grant_we = (a_rd != '0);
        end else if (fifo_pop) begin
            grant_we   = 1'b1;
            grant_rd   = head_rd;
            grant_data = head_data;
        end
    end

    // RD/data only load on a real write; otherwise they hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_regWrite  <= 1'b0;
            rf_RD        <= '0;
            rf_writeData <= '0;
        end else begin
            rf_regWrite <= grant_we;
            if (grant_we) begin
                rf_RD        <= grant_rd;
                rf_writeData <= grant_data;
            end
        end
    end

    always_comb begin
        logic hit1, hit2;
        hit1 = rf_regWrite && (rf_RD == RS1);
        hit2 = rf_regWrite && (rf_RD == RS2);
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (entry_valid[i] && (entry_rd[i] == RS1)) hit1 = 1'b1;
            if (entry_valid[i] && (entry_rd[i] == RS2)) hit2 = 1'b1;
        end
        rs1_pending = hit1 && (RS1 != '0);
        rs2_pending = hit2 && (RS2 != '0);
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default parameters).
// Inputs change 1 ns after posedge; registered outputs are checked there,
// combinational outputs 1 ns after inputs settle.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_rd = '0, b_rd = '0, RS1 = '0, RS2 = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, rf_regWrite, rs1_pending, rs2_pending;
    logic [4:0]  rf_RD;
    logic [31:0] rf_writeData;
    logic [1:0]  b_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    wb_arbiter #(.n(32), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .rf_regWrite  (rf_regWrite),
        .rf_RD        (rf_RD),
        .rf_writeData (rf_writeData),
        .RS1          (RS1),
        .RS2          (RS2),
        .rs1_pending  (rs1_pending),
        .rs2_pending  (rs2_pending),
        .b_count      (b_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RS1 = 5'd5;
        RS2 = 5'd7;
        #2;
        n_cmp++; if (rf_regWrite !== 1'b0) begin n_err++; $display("FAIL reset_we got %0b want 0", rf_regWrite); end
        n_cmp++; if (rf_RD !== 5'd0) begin n_err++; $display("FAIL reset_rd got %0d want 0", rf_RD); end
        n_cmp++; if (rf_writeData !== 32'd0) begin n_err++; $display("FAIL reset_data got %h want 0", rf_writeData); end
        n_cmp++; if (b_count !== 2'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", b_count); end
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL reset_a_ready got %0b want 1", a_ready); end
        n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL reset_b_ready got %0b want 1", b_ready); end
        n_cmp++; if ({rs1_pending, rs2_pending} !== 2'b00) begin n_err++; $display("FAIL reset_pending got %b want 00", {rs1_pending, rs2_pending}); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if ({a_ready, b_ready, rf_regWrite} !== 3'b110) begin n_err++; $display("FAIL post_reset got %b want 110", {a_ready, b_ready, rf_regWrite}); end
    endtask

    task automatic test_a_only();
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'hDEADBEEF; RS1 = 5'd5;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL a_only_ready got %0b want 1", a_ready); end
        n_cmp++; if (rs1_pending !== 1'b0) begin n_err++; $display("FAIL a_only_pend0 got %0b want 0", rs1_pending); end
        tick();
        a_valid = 1'b0;
        n_cmp++; if (rf_regWrite !== 1'b1) begin n_err++; $display("FAIL a_only_we got %0b want 1", rf_regWrite); end
        n_cmp++; if (rf_RD !== 5'd5) begin n_err++; $display("FAIL a_only_rd got %0d want 5", rf_RD); end
        n_cmp++; if (rf_writeData !== 32'hDEADBEEF) begin n_err++; $display("FAIL a_only_data got %h want deadbeef", rf_writeData); end
        #1;
        n_cmp++; if (rs1_pending !== 1'b1) begin n_err++; $display("FAIL a_only_pend1 got %0b want 1", rs1_pending); end
        tick();
        n_cmp++; if (rf_regWrite !== 1'b0) begin n_err++; $display("FAIL a_only_idle got %0b want 0", rf_regWrite); end
        n_cmp++; if (rs1_pending !== 1'b0) begin n_err++; $display("FAIL a_only_pend_clr got %0b want 0", rs1_pending); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            a_valid = 1'b1; a_rd = 5'(i + 12); a_data = 32'h100 + 32'(i);
            tick();
            n_cmp++; if ({rf_regWrite, rf_RD} !== {1'b1, 5'(i + 12)}) begin n_err++; $display("FAIL b2b_rd[%0d] got %0b/%0d want 1/%0d", i, rf_regWrite, rf_RD, i + 12); end
            n_cmp++; if (rf_writeData !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", i, rf_writeData, 32'h100 + 32'(i)); end
        end
        a_valid = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h11;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h22;
        RS2 = 5'd4;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        n_cmp++; if ({rf_regWrite, rf_RD, rf_writeData} !== {1'b1, 5'd3, 32'h11}) begin n_err++; $display("FAIL cont_first got %0b/%0d/%h want 1/3/11", rf_regWrite, rf_RD, rf_writeData); end
        n_cmp++; if (b_count !== 2'd1) begin n_err++; $display("FAIL cont_count1 got %0d want 1", b_count); end
        #1;
        n_cmp++; if (rs2_pending !== 1'b1) begin n_err++; $display("FAIL cont_pend_fifo got %0b want 1", rs2_pending); end
        tick();
        n_cmp++; if ({rf_regWrite, rf_RD, rf_writeData} !== {1'b1, 5'd4, 32'h22}) begin n_err++; $display("FAIL cont_second got %0b/%0d/%h want 1/4/22", rf_regWrite, rf_RD, rf_writeData); end
        n_cmp++; if (b_count !== 2'd0) begin n_err++; $display("FAIL cont_count0 got %0d want 0", b_count); end
        tick();
        n_cmp++; if (rf_regWrite !== 1'b0) begin n_err++; $display("FAIL cont_idle got %0b want 0", rf_regWrite); end
    endtask

`ifndef WB_ARB_AGE_EN
    task automatic test_full_fifo();
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA;
        b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h66;
        #1;
        n_cmp++; if (b_ready !== 1'b1) begin n_err++; $display("FAIL full_ready0 got %0b want 1", b_ready); end
        tick();
        b_rd = 5'd7; b_data = 32'h77;
        #1;
        n_cmp++; if ({b_count, b_ready} !== {2'd1, 1'b1}) begin n_err++; $display("FAIL full_push1 got %0d/%0b want 1/1", b_count, b_ready); end
        tick();
        b_rd = 5'd8; b_data = 32'h88;
        #1;
        n_cmp++; if ({b_count, b_ready} !== {2'd2, 1'b0}) begin n_err++; $display("FAIL full_push2 got %0d/%0b want 2/0", b_count, b_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if ({rf_regWrite, rf_RD, b_count} !== {1'b1, 5'd1, 2'd2}) begin n_err++; $display("FAIL full_hold[%0d] got %0b/%0d/%0d want 1/1/2", k, rf_regWrite, rf_RD, b_count); end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        tick();
        n_cmp++; if ({rf_regWrite, rf_RD, rf_writeData, b_count} !== {1'b1, 5'd6, 32'h66, 2'd1}) begin n_err++; $display("FAIL full_drain6 got %0b/%0d/%h/%0d want 1/6/66/1", rf_regWrite, rf_RD, rf_writeData, b_count); end
        tick();
        n_cmp++; if ({rf_regWrite, rf_RD, rf_writeData, b_count} !== {1'b1, 5'd7, 32'h77, 2'd0}) begin n_err++; $display("FAIL full_drain7 got %0b/%0d/%h/%0d want 1/7/77/0", rf_regWrite, rf_RD, rf_writeData, b_count); end
        tick();
        n_cmp++; if (rf_regWrite !== 1'b0) begin n_err++; $display("FAIL full_idle got %0b want 0", rf_regWrite); end
    endtask
`else
    task automatic test_age();
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
        tick();
        b_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL age_ready[%0d] got %0b want 1", k, a_ready); end
            tick();
            n_cmp++; if ({rf_regWrite, rf_RD} !== {1'b1, 5'd1}) begin n_err++; $display("FAIL age_a[%0d] got %0b/%0d want 1/1", k, rf_regWrite, rf_RD); end
        end
        #1;
        n_cmp++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL age_block got %0b want 0", a_ready); end
        tick();
        n_cmp++; if ({rf_regWrite, rf_RD, rf_writeData, b_count} !== {1'b1, 5'd9, 32'h99, 2'd0}) begin n_err++; $display("FAIL age_grant got %0b/%0d/%h/%0d want 1/9/99/0", rf_regWrite, rf_RD, rf_writeData, b_count); end
        n_cmp++; if (a_ready !== 1'b1) begin n_err++; $display("FAIL age_release got %0b want 1", a_ready); end
        a_valid = 1'b0;
        tick();
    endtask
`endif

    task automatic test_rd_zero();
        a_valid = 1'b1; a_rd = 5'd0; a_data = 32'h55;
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h66;
        RS1 = 5'd0;
        #1;
        n_cmp++; if ({a_ready, b_ready, rs1_pending} !== 3'b110) begin n_err++; $display("FAIL rd0_comb got %b want 110", {a_ready, b_ready, rs1_pending}); end
        tick();
        a_valid = 1'b0;
        n_cmp++; if ({rf_regWrite, b_count} !== {1'b0, 2'd0}) begin n_err++; $display("FAIL rd0_both got %0b/%0d want 0/0", rf_regWrite, b_count); end
        tick();
        b_valid = 1'b0;
        n_cmp++; if ({rf_regWrite, b_count} !== {1'b0, 2'd0}) begin n_err++; $display("FAIL rd0_b got %0b/%0d want 0/0", rf_regWrite, b_count); end
        tick();
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'hA1;
        b_valid = 1'b1; b_rd = 5'd10; b_data = 32'h10;
        tick();
        b_rd = 5'd11; b_data = 32'h11;
        tick();
        b_valid = 1'b0;
        RS1 = 5'd10;
        #1;
        n_cmp++; if ({rf_regWrite, b_count, rs1_pending} !== {1'b1, 2'd2, 1'b1}) begin n_err++; $display("FAIL rmid_pre got %0b/%0d/%0b want 1/2/1", rf_regWrite, b_count, rs1_pending); end
        rst = 1'b1;
        #1;
        n_cmp++; if ({rf_regWrite, b_count, rs1_pending} !== {1'b0, 2'd0, 1'b0}) begin n_err++; $display("FAIL rmid_async got %0b/%0d/%0b want 0/0/0", rf_regWrite, b_count, rs1_pending); end
        n_cmp++; if ({a_ready, b_ready} !== 2'b11) begin n_err++; $display("FAIL rmid_ready got %b want 11", {a_ready, b_ready}); end
        a_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if ({rf_regWrite, b_count} !== {1'b0, 2'd0}) begin n_err++; $display("FAIL rmid_after[%0d] got %0b/%0d want 0/0", k, rf_regWrite, b_count); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_a_only();
        test_back_to_back();
        test_contention();
`ifndef WB_ARB_AGE_EN
        test_full_fifo();
`else
        test_age();
`endif
        test_rd_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
